// File: rtl/kyber_pkg.sv
// Shared Kyber constants and coefficient types used by the modular add/sub datapath.
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int COEF_W  = 12;
    localparam int IDX_W   = 8;

    typedef logic [COEF_W-1:0] coef_t;
    typedef logic [IDX_W-1:0]  idx_t;

    // A 12-bit value is below 2Q, so one conditional subtraction fully reduces it.
    function automatic coef_t reduce_once(input coef_t x);
        coef_t q_c;
        q_c = COEF_W'(KYBER_Q);
        return (x >= q_c) ? (x - q_c) : x;
    endfunction

endpackage

// File: rtl/poly_mod_sub_stream_if.sv
// Stream bundle for the coefficient subtractor: input pair channel and result channel.
interface poly_mod_sub_stream_if;
    import kyber_pkg::*;

    logic  in_valid;
    logic  in_ready;
    coef_t in_a;
    coef_t in_b;
    logic  out_valid;
    logic  out_ready;
    coef_t out_c;
    idx_t  out_idx;
    logic  out_last;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_c, out_idx, out_last
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_c, out_idx, out_last
    );

endinterface

// File: rtl/mod_q_sub_core.sv
// Combinational (a - b) mod Q for operands already reduced into 0..Q-1.
module mod_q_sub_core #(
    parameter int WIDTH = 12,
    parameter int Q     = 3329
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_c
);

    localparam logic [WIDTH:0] Q_EXT = (WIDTH+1)'(Q);

    logic [WIDTH:0] w_diff;
    logic [WIDTH:0] w_wrapped;

    // One extra bit holds the sign of a - b; a negative difference is lifted back by adding Q.
    assign w_diff    = {1'b0, i_a} - {1'b0, i_b};
    assign w_wrapped = w_diff + Q_EXT;
    assign o_c       = w_diff[WIDTH] ? w_wrapped[WIDTH-1:0] : w_diff[WIDTH-1:0];

endmodule

// File: rtl/poly_mod_sub_stream.sv
// Two-stage streaming (a - b) mod 3329 with coefficient index tagging and last-beat flag.
module poly_mod_sub_stream
    import kyber_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    poly_mod_sub_stream_if.slave bus
);

    logic  w_advance;
    logic  w_in_fire;
    coef_t w_a_red;
    coef_t w_b_red;
    coef_t w_c;

    logic  r_s1_valid;
    coef_t r_s1_a;
    coef_t r_s1_b;
    idx_t  r_s1_idx;
    idx_t  r_in_idx;

    logic  r_out_valid;
    coef_t r_out_c;
    idx_t  r_out_idx;
    logic  r_out_last;

    assign w_advance = !r_out_valid || bus.out_ready;
    assign w_in_fire = bus.in_valid && w_advance;
    assign w_a_red   = reduce_once(bus.in_a);
    assign w_b_red   = reduce_once(bus.in_b);

    assign bus.in_ready  = w_advance;
    assign bus.out_valid = r_out_valid;
    assign bus.out_c     = r_out_c;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;

    mod_q_sub_core #(
        .WIDTH (COEF_W),
        .Q     (KYBER_Q)
    ) u_core (
        .i_a (r_s1_a),
        .i_b (r_s1_b),
        .o_c (w_c)
    );

    // Stage 1: reduce the accepted pair, tag it with the running index, and step the index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_idx   <= '0;
            r_in_idx   <= '0;
        end else if (w_advance) begin
            r_s1_valid <= bus.in_valid;
            if (w_in_fire) begin
                r_s1_a   <= w_a_red;
                r_s1_b   <= w_b_red;
                r_s1_idx <= r_in_idx;
                r_in_idx <= r_in_idx + IDX_W'(1);
            end
        end
    end

    // Stage 2: register the subtraction result; everything holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_c     <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_c    <= w_c;
                r_out_idx  <= r_s1_idx;
                r_out_last <= (r_s1_idx == IDX_W'(KYBER_N - 1));
            end
        end
    end

endmodule

// File: tb/tb_poly_mod_sub_stream.sv
// Self-checking bench for poly_mod_sub_stream: directed vectors plus a scoreboard-driven random run.
module tb_poly_mod_sub_stream;
    import kyber_pkg::*;

    typedef struct {
        int    a;
        int    b;
        int    expC;
        int    expIdx;
        string name;
    } vec_t;

    typedef struct {
        int c;
        int idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    poly_mod_sub_stream_if bus ();

    poly_mod_sub_stream dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t vecs[8];
    exp_t sbQueue[$];

    int   assertCount = 0;
    int   failCount   = 0;
    int   modelIdx    = 0;
    int   outCount    = 0;
    int   lastCount   = 0;
    int   acceptCount = 0;
    logic lastInReady = 1'b0;
    logic prevHeld    = 1'b0;
    int   prevC       = 0;
    int   prevIdx     = 0;
    int   prevLast    = 0;

    // Reference: mathematical (a - b) mod 3329 on plain integers.
    function automatic int modelSub(input int a, input int b);
        int d;
        d = (a - b) % 3329;
        if (d < 0) d = d + 3329;
        return d;
    endfunction

    function automatic int pickCoef();
        int r;
        r = int'($urandom_range(0, 7));
        case (r)
            0:       return 0;
            1:       return 3328;
            2:       return 3329;
            3:       return 4095;
            default: return int'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock of stimulus; outputs are sampled mid-cycle and scored against the model.
    task automatic applyStimulus(input logic v, input int a, input int b, input logic ordy);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_a      = coef_t'(a);
        bus.in_b      = coef_t'(b);
        bus.out_ready = ordy;
        #1;
        if (prevHeld) begin
            checkOutput("hold_valid", int'(bus.out_valid), 1);
            checkOutput("hold_c", int'(bus.out_c), prevC);
            checkOutput("hold_idx", int'(bus.out_idx), prevIdx);
            checkOutput("hold_last", int'(bus.out_last), prevLast);
        end
        lastInReady = bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            outCount++;
            if (bus.out_last) lastCount++;
            checkOutput("sb_nonempty", int'(sbQueue.size() > 0), 1);
            if (sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                checkOutput("sb_c", int'(bus.out_c), e.c);
                checkOutput("sb_idx", int'(bus.out_idx), e.idx);
                checkOutput("sb_last", int'(bus.out_last), int'(e.idx == 255));
            end
        end
        prevHeld = bus.out_valid && !bus.out_ready;
        prevC    = int'(bus.out_c);
        prevIdx  = int'(bus.out_idx);
        prevLast = int'(bus.out_last);
        if (v && bus.in_ready) begin
            e.c   = modelSub(a, b);
            e.idx = modelIdx;
            sbQueue.push_back(e);
            modelIdx = (modelIdx + 1) % 256;
            acceptCount++;
        end
    endtask

    // Holds reset with a valid pair offered, which must be ignored, then clears the model.
    task automatic doReset(input int cycles);
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = coef_t'($urandom_range(0, 4095));
        bus.in_b      = coef_t'($urandom_range(0, 4095));
        bus.out_ready = 1'b1;
        repeat (cycles) @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        sbQueue.delete();
        modelIdx    = 0;
        prevHeld    = 1'b0;
        outCount    = 0;
        lastCount   = 0;
        acceptCount = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sbQueue.size() > 0; k++) begin
            applyStimulus(1'b0, 0, 0, 1'b1);
        end
        checkOutput("drain_empty", sbQueue.size(), 0);
    endtask

    // Single isolated pair: checks the two-cycle latency and the exact result.
    task automatic sendOne(input vec_t v);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_a      = coef_t'(v.a);
        bus.in_b      = coef_t'(v.b);
        bus.out_ready = 1'b1;
        #1;
        checkOutput({v.name, "_in_ready"}, int'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checkOutput({v.name, "_early_valid"}, int'(bus.out_valid), 0);
        @(negedge clk);
        #1;
        checkOutput({v.name, "_valid"}, int'(bus.out_valid), 1);
        checkOutput({v.name, "_c"}, int'(bus.out_c), v.expC);
        checkOutput({v.name, "_idx"}, int'(bus.out_idx), v.expIdx);
        checkOutput({v.name, "_last"}, int'(bus.out_last), int'(v.expIdx == 255));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{0,    1,    3328, 0, "zero_minus_one"};
        vecs[1] = '{3328, 3328, 0,    1, "equal_max"};
        vecs[2] = '{4095, 0,    766,  2, "unreduced_a"};
        vecs[3] = '{100,  4095, 2663, 3, "unreduced_b"};
        vecs[4] = '{3329, 3329, 0,    4, "both_q"};
        vecs[5] = '{0,    3328, 1,    5, "zero_minus_qm1"};
        vecs[6] = '{1234, 1234, 0,    6, "equal_mid"};
        vecs[7] = '{3328, 0,    3328, 7, "max_minus_zero"};

        // Reset state
        doReset(3);
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_out_c", int'(bus.out_c), 0);
        checkOutput("rst_out_idx", int'(bus.out_idx), 0);
        checkOutput("rst_out_last", int'(bus.out_last), 0);
        checkOutput("rst_in_ready", int'(bus.in_ready), 1);

        // Directed vectors with latency check
        for (int i = 0; i < 8; i++) begin
            sendOne(vecs[i]);
        end

        // Full polynomial back-to-back, then the first coefficient of the next one
        doReset(2);
        for (int i = 0; i < 257; i++) begin
            applyStimulus(1'b1, pickCoef(), pickCoef(), 1'b1);
            checkOutput("poly_in_ready", int'(lastInReady), 1);
        end
        drain();
        checkOutput("poly_out_count", outCount, 257);
        checkOutput("poly_last_count", lastCount, 1);

        // Consumer stall with three pairs offered
        doReset(2);
        applyStimulus(1'b1, 10, 20, 1'b0);
        applyStimulus(1'b1, 3000, 5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4000, 100, 1'b0);
            checkOutput("stall_in_ready", int'(lastInReady), 0);
        end
        applyStimulus(1'b1, 4000, 100, 1'b1);
        checkOutput("release_in_ready", int'(lastInReady), 1);
        drain();
        checkOutput("stall_out_count", outCount, 3);
        checkOutput("stall_accept_count", acceptCount, 3);

        // Reset mid-stream discards in-flight beats and restarts the index
        doReset(1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, pickCoef(), pickCoef(), 1'b1);
        end
        doReset(1);
        checkOutput("midrst_out_valid", int'(bus.out_valid), 0);
        applyStimulus(1'b1, 7, 3, 1'b1);
        drain();
        checkOutput("midrst_out_count", outCount, 1);

        // Random traffic against the scoreboard
        doReset(1);
        for (int cyc = 0; cyc < 60000 && acceptCount < 10000; cyc++) begin
            applyStimulus($urandom_range(0, 99) < 70, pickCoef(), pickCoef(),
                          $urandom_range(0, 99) < 70);
        end
        checkOutput("random_accept_count", acceptCount, 10000);
        drain();
        checkOutput("random_out_count", outCount, acceptCount);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
